// File: rtl/clock_period_monitor_if.sv
// Bundle between the period monitor and the logic it serves: the divided
// clock going in, half-period measurements and lock/loss status coming out.
interface clock_period_monitor_if #(
    parameter int CNT_W = 32
);
    logic             sclk_in;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             mismatch;
    logic             locked;
    logic             lost;

    // Monitor side.
    modport master (
        input  sclk_in,
        output half_period,
        output period_valid,
        output mismatch,
        output locked,
        output lost
    );

    // Environment side: supplies sclk, consumes the status.
    modport slave (
        output sclk_in,
        input  half_period,
        input  period_valid,
        input  mismatch,
        input  locked,
        input  lost
    );
endinterface

// File: rtl/clock_period_monitor.sv
// Measures the half-period of an asynchronous divided clock in clk cycles,
// reporting each interval and tracking lock/loss against an expected value.
module clock_period_monitor #(
    parameter int CNT_W       = 32,
    parameter int EXPECT_HALF = 5000001,
    parameter int TOL         = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 10000002
) (
    input  logic                  clk,
    input  logic                  reset,
    clock_period_monitor_if.master bus
);
    localparam int MC_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W:0]   EXP_W    = (CNT_W+1)'(EXPECT_HALF);
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0]   ONE_W    = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [MC_W-1:0]  LOCK_W   = MC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

    state_t           state_reg, state_next;
    logic             sync1_reg, sync2_reg, hist_reg;
    logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
    logic [MC_W-1:0]  match_cnt_reg, match_cnt_next;
    logic [CNT_W-1:0] half_period_reg, half_period_next;
    logic             period_valid_reg, period_valid_next;
    logic             mismatch_reg, mismatch_next;

    logic             edge_det, timeout_hit, in_tol, lock_reached;
    logic [CNT_W:0]   meas, dev;

    // Both sclk polarities count as an edge; the history flop trails the synchroniser.
    assign edge_det     = sync2_reg ^ hist_reg;
    assign timeout_hit  = !edge_det && (run_cnt_reg == TMO_LAST);
    assign meas         = {1'b0, run_cnt_reg} + ONE_W;
    assign dev          = (meas >= EXP_W) ? (meas - EXP_W) : (EXP_W - meas);
    assign in_tol       = (dev <= TOL_W);
    assign lock_reached = (match_cnt_reg + MC_W'(1)) == LOCK_W;

    assign run_cnt_next = edge_det          ? '0 :
                          (&run_cnt_reg)    ? run_cnt_reg :
                                              run_cnt_reg + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            sync1_reg        <= 1'b0;
            sync2_reg        <= 1'b0;
            hist_reg         <= 1'b0;
            run_cnt_reg      <= '0;
            match_cnt_reg    <= '0;
            half_period_reg  <= '0;
            period_valid_reg <= 1'b0;
            mismatch_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            sync1_reg        <= bus.sclk_in;
            sync2_reg        <= sync1_reg;
            hist_reg         <= sync2_reg;
            run_cnt_reg      <= run_cnt_next;
            match_cnt_reg    <= match_cnt_next;
            half_period_reg  <= half_period_next;
            period_valid_reg <= period_valid_next;
            mismatch_reg     <= mismatch_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (edge_det) begin
                    state_next     = ACQUIRE;
                    match_cnt_next = '0;
                end else if (timeout_hit) begin
                    state_next     = LOST;
                    match_cnt_next = '0;
                end
            end
            ACQUIRE: begin
                if (edge_det) begin
                    if (!in_tol) begin
                        match_cnt_next = '0;
                    end else if (lock_reached) begin
                        state_next     = LOCKED;
                        match_cnt_next = '0;
                    end else begin
                        match_cnt_next = match_cnt_reg + MC_W'(1);
                    end
                end else if (timeout_hit) begin
                    state_next     = LOST;
                    match_cnt_next = '0;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    if (!in_tol) begin
                        state_next     = ACQUIRE;
                        match_cnt_next = '0;
                    end
                end else if (timeout_hit) begin
                    state_next     = LOST;
                    match_cnt_next = '0;
                end
            end
            LOST: begin
                // The interval that ends here spans the outage, so it is not measured.
                if (edge_det) begin
                    state_next     = ACQUIRE;
                    match_cnt_next = '0;
                end
            end
            default: begin
                state_next     = IDLE;
                match_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        period_valid_next = edge_det && ((state_reg == ACQUIRE) || (state_reg == LOCKED));
        mismatch_next     = period_valid_next && !in_tol;
        half_period_next  = period_valid_next ? meas[CNT_W-1:0] : half_period_reg;
    end

    assign bus.half_period  = half_period_reg;
    assign bus.period_valid = period_valid_reg;
    assign bus.mismatch     = mismatch_reg;
    assign bus.locked       = (state_reg == LOCKED);
    assign bus.lost         = (state_reg == LOST);
endmodule

// File: tb/tb_clock_period_monitor.sv
// Scoreboard bench for clock_period_monitor: expected pulses are queued as
// sclk edges are driven and checked when period_valid appears.
module tb_clock_period_monitor;
    localparam int CNT_W       = 16;
    localparam int EXPECT_HALF = 10;
    localparam int TOL         = 1;
    localparam int LOCK_COUNT  = 3;
    localparam int TIMEOUT     = 25;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    clock_period_monitor_if #(.CNT_W(CNT_W)) bus();

    clock_period_monitor #(
        .CNT_W(CNT_W), .EXPECT_HALF(EXPECT_HALF), .TOL(TOL),
        .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] hp;
        logic             mis;
        logic             lk;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   since_toggle = 0;
    bit   lost_seen    = 0;

    // Output monitor: pops the scoreboard on each period_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.lost) lost_seen = 1;
            n_compared++;
            if (bus.locked && bus.lost) begin
                n_mismatched++;
                $display("FAIL locked_and_lost: locked=%0b lost=%0b, required not both 1", bus.locked, bus.lost);
            end
            n_compared++;
            if (bus.mismatch && !bus.period_valid) begin
                n_mismatched++;
                $display("FAIL mismatch_without_pv: mismatch=1 period_valid=0, required mismatch=0");
            end
            if (bus.period_valid) begin
                $display("pulse t=%0t half_period=%0d mismatch=%0b locked=%0b lost=%0b",
                         $time, bus.half_period, bus.mismatch, bus.locked, bus.lost);
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("FAIL unexpected_pulse: period_valid=1 half_period=%0d, required no pulse", bus.half_period);
                end else begin
                    e = exp_q.pop_front();
                    n_compared += 2;
                    if (bus.half_period !== e.hp) begin
                        n_mismatched++;
                        $display("FAIL half_period: got %0d, required %0d", bus.half_period, e.hp);
                    end
                    if (bus.mismatch !== e.mis) begin
                        n_mismatched++;
                        $display("FAIL mismatch_pulse: got %0b, required %0b (half_period=%0d)", bus.mismatch, e.mis, e.hp);
                    end
                    if (bus.locked !== e.lk) begin
                        n_mismatched++;
                        $display("FAIL locked_at_pulse: got %0b, required %0b (half_period=%0d)", bus.locked, e.lk, e.hp);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            since_toggle++;
        end
    endtask

    // Toggle sclk_in gap clk cycles after its previous toggle, queueing the pulse it should cause.
    task automatic sclk_edge(input int gap, input bit pv, input int hp, input bit mis, input bit lk);
        exp_t e;
        step(gap - since_toggle);
        if (pv) begin
            e.hp  = CNT_W'(hp);
            e.mis = mis;
            e.lk  = lk;
            exp_q.push_back(e);
        end
        bus.sclk_in  = ~bus.sclk_in;
        since_toggle = 0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %0b, required %0b", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_compared++;
        if (bus.half_period !== '0 || bus.period_valid !== 1'b0 || bus.mismatch !== 1'b0 ||
            bus.locked !== 1'b0 || bus.lost !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s: hp=%0d pv=%0b mis=%0b locked=%0b lost=%0b, required all 0",
                     tag, bus.half_period, bus.period_valid, bus.mismatch, bus.locked, bus.lost);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.sclk_in = 1'b0;
        step(2);
        reset        = 1'b0;
        since_toggle = 0;
    endtask

    task automatic test_reset();
        do_reset();
        check_all_zero("reset_state");
        $display("reset released, outputs sampled");
    endtask

    task automatic test_lock();
        sclk_edge(10, 0, 0, 0, 0);
        sclk_edge(10, 1, 10, 0, 0);
        sclk_edge(10, 1, 10, 0, 0);
        sclk_edge(10, 1, 10, 0, 1);
        step(5);
        check_bit("locked_after_acquire", bus.locked, 1'b1);
    endtask

    task automatic test_tolerance();
        sclk_edge(11, 1, 11, 0, 1);
        sclk_edge(9,  1, 9,  0, 1);
        sclk_edge(11, 1, 11, 0, 1);
        sclk_edge(12, 1, 12, 1, 0);
        sclk_edge(10, 1, 10, 0, 0);
        sclk_edge(10, 1, 10, 0, 0);
        sclk_edge(10, 1, 10, 0, 1);
        step(5);
        check_bit("relocked_after_bad", bus.locked, 1'b1);
    endtask

    task automatic test_lost();
        while (!bus.lost && since_toggle < 80) step(1);
        n_compared++;
        if (since_toggle != 28) begin
            n_mismatched++;
            $display("FAIL lost_latency: lost seen %0d clk after last toggle, required 28", since_toggle);
        end
        check_bit("locked_when_lost", bus.locked, 1'b0);
        sclk_edge(since_toggle + 2, 0, 0, 0, 0);
        step(4);
        check_bit("lost_cleared", bus.lost, 1'b0);
        sclk_edge(10, 1, 10, 0, 0);
        sclk_edge(10, 1, 10, 0, 0);
        sclk_edge(10, 1, 10, 0, 1);
        step(4);
        check_bit("locked_after_lost", bus.locked, 1'b1);
    endtask

    task automatic test_timeout_boundary();
        lost_seen = 0;
        sclk_edge(25, 1, 25, 1, 0);
        step(6);
        check_bit("no_lost_at_25", lost_seen, 1'b0);
        sclk_edge(26, 0, 0, 0, 0);
        step(4);
        check_bit("lost_at_26", lost_seen, 1'b1);
        check_bit("lost_recovered", bus.lost, 1'b0);
        sclk_edge(10, 1, 10, 0, 0);
        sclk_edge(10, 1, 10, 0, 0);
        sclk_edge(10, 1, 10, 0, 1);
        step(4);
        check_bit("locked_before_reset", bus.locked, 1'b1);
    endtask

    task automatic test_reset_on_edge();
        sclk_edge(10, 0, 0, 0, 0);
        step(2);
        reset = 1'b1;
        step(1);
        check_all_zero("reset_on_edge");
        bus.sclk_in = 1'b0;
        step(1);
        reset        = 1'b0;
        since_toggle = 0;
        sclk_edge(10, 0, 0, 0, 0);
        sclk_edge(10, 1, 10, 0, 0);
        step(5);
        check_bit("locked_after_reset", bus.locked, 1'b0);
    endtask

    task automatic test_duty();
        do_reset();
        sclk_edge(10, 0, 0, 0, 0);
        sclk_edge(10, 1, 10, 0, 0);
        sclk_edge(9,  1, 9,  0, 0);
        sclk_edge(10, 1, 10, 0, 1);
        sclk_edge(9,  1, 9,  0, 1);
        step(5);
        check_bit("locked_duty", bus.locked, 1'b1);
    endtask

    initial begin
        bus.sclk_in = 1'b0;
        test_reset();
        test_lock();
        test_tolerance();
        test_lost();
        test_timeout_boundary();
        test_reset_on_edge();
        test_duty();
        step(6);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL missing_pulses: %0d expected pulses never arrived, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/clock_period_monitor.md
Name: clock_period_monitor

Overview:
Receive-side companion to the clock divider. Takes a slow divided clock (sclk) generated elsewhere, synchronises it into the fast system clock domain and measures each half-period in clk cycles. It reports each measurement, asserts lock after consecutive in-tolerance half-periods and flags loss when edges stop. Used to check divider output and to gate logic that depends on sclk being alive.

Parameters:
CNT_W, 32, width of interval counter and half_period output
EXPECT_HALF, 5000001, expected clk cycles between consecutive sclk edges (divider terminal count + 1)
TOL, 2, allowed absolute deviation from EXPECT_HALF, in clk cycles
LOCK_COUNT, 4, consecutive in-tolerance measurements required to assert locked (>=1)
TIMEOUT, 10000002, clk cycles without a detected edge before lost asserts (> EXPECT_HALF+TOL)

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
sclk_in  input  1  divided clock, asynchronous to clk
half_period  output  CNT_W  last measured edge-to-edge interval, clk cycles
period_valid  output  1  one-cycle pulse: half_period updated this cycle
mismatch  output  1  one-cycle pulse: the measurement just reported is out of tolerance
locked  output  1  level: LOCK_COUNT consecutive in-tolerance measurements seen, none bad since
lost  output  1  level: no edge for TIMEOUT cycles

Behaviour:
- Reset (sync, active-high, sampled on clk rise): all outputs 0, counters 0, sync flops 0, state IDLE.
- Input path: 2-flop synchroniser on sclk_in, then 1 history flop; edge = sync_out XOR history (both polarities). Edge is seen 3 clk after the sclk_in transition.
- Interval counter run_cnt: cleared to 0 on edge cycle, else +1, saturating at all-ones. Measurement m = run_cnt + 1, evaluated on edge cycle. An sclk toggling every N clk gives m = N.
- Tolerance: in-tol when |m - EXPECT_HALF| <= TOL, computed at CNT_W+1 bits, no wrap.
- Registered outputs: half_period, period_valid and mismatch update 1 clk after the edge cycle. half_period holds between measurements.
- States:
  - IDLE: no measurements. Edge -> ACQUIRE. The first interval is partial and is discarded.
  - ACQUIRE: each edge emits period_valid with half_period = m.
    - In-tol: match_cnt+1; when it reaches LOCK_COUNT -> LOCKED, locked=1 in the same cycle as that period_valid.
    - Out-of-tol: match_cnt=0, mismatch pulse.
  - LOCKED: each edge emits period_valid. Out-of-tol: mismatch pulse, locked=0, match_cnt=0 -> ACQUIRE.
  - LOST: lost=1, locked=0. Next edge -> ACQUIRE, lost=0, interval discarded, no period_valid.
- Timeout: in IDLE, ACQUIRE or LOCKED, if no edge and run_cnt == TIMEOUT-1 -> LOST next cycle, match_cnt=0. In IDLE, the count runs from reset release.
- Simultaneous edge and timeout condition: edge wins, no lost.
- Reset mid-operation: next cycle identical to post-reset; any in-flight measurement is dropped, no pulse.
- locked and lost are never both 1. period_valid and mismatch never fire without an edge.
- Saturated run_cnt in ACQUIRE is not reachable, because timeout fires first.

Test Plan:
Bench params: CNT_W=16, EXPECT_HALF=10, TOL=1, LOCK_COUNT=3, TIMEOUT=25.
1. Reset 2 cycles, sclk_in toggles every 10 clk -> no pulse on 1st edge; period_valid with half_period=10 at 2nd, 3rd, 4th edges; locked=1 together with the 3rd pulse; mismatch stays 0.
2. While locked, intervals 11, 9, 11 -> half_period=11, 9, 11, locked stays 1. Then interval 12 -> half_period=12, mismatch pulse, locked=0. Then three intervals of 10 -> relock.
3. While locked, hold sclk_in constant -> lost=1 and locked=0, 25 clk after the last detected edge (+1 registered), no period_valid. Resume toggling every 10 -> lost clears on 1st edge, no pulse; locked after 3 further edges.
4. Interval exactly 25 -> edge beats timeout: half_period=25, mismatch pulse, lost stays 0. Interval 26 -> lost asserts.
5. Assert reset mid-LOCKED coinciding with an edge -> next cycle all outputs 0, no period_valid. After release, first edge is discarded.
6. Glitch-free duty variation, high 10 and low 9 repeating -> alternating half_period 10/9, all in tolerance, locked after 3 measurements.
